// File: rtl/dcache_wb.sv
// Direct-mapped, write-back / write-allocate data cache with a single-line
// memory port (write-back then refill) and saturating hit/miss statistics.
module dcache_wb #(
  parameter int DATA_W = 32,
  parameter int SETS   = 16,
  parameter int WORDS  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_rd,
  input  logic                    cpu_wr,
  input  logic [31:0]             cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    stall,
  output logic                    hit,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [WORDS*DATA_W-1:0] mem_wdata,
  input  logic [WORDS*DATA_W-1:0] mem_rdata,
  input  logic                    mem_ready,
  output logic [CNT_W-1:0]        hit_cnt,
  output logic [CNT_W-1:0]        miss_cnt
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, DONE} state_t;
  typedef logic [WORDS-1:0][DATA_W-1:0] line_t;

  state_t r_state, w_next;

  logic [SETS-1:0]  r_valid;
  logic [SETS-1:0]  r_dirty;
  logic [TAG_W-1:0] r_tag  [SETS];
  line_t            r_data [SETS];

  // Request captured at the miss edge; the miss sequence uses only this copy.
  logic [TAG_W-1:0]  r_req_tag;
  logic [IDX_W-1:0]  r_req_idx;
  logic [OFF_W-1:0]  r_req_off;
  logic              r_req_wr;
  logic [DATA_W-1:0] r_req_wdata;

  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_req;
  logic             w_idle;
  logic             w_match;
  logic             w_hit;
  logic             w_miss;
  logic             w_install;
  line_t            w_fill;

  assign w_off   = cpu_addr[2 +: OFF_W];
  assign w_idx   = cpu_addr[2 + OFF_W +: IDX_W];
  assign w_tag   = cpu_addr[31 -: TAG_W];
  assign w_req   = cpu_rd | cpu_wr;
  assign w_idle  = (r_state == IDLE) && !reset;
  assign w_match = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_hit   = w_idle && w_req && w_match;
  assign w_miss  = w_idle && w_req && !w_match;

  assign w_install = (r_state == REFILL) && mem_ready;

  assign hit      = w_hit;
  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;

  // A store miss merges its word into the incoming line before install.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see earlier results.
    w_fill = mem_rdata;
    if (r_req_wr) w_fill[r_req_off] = r_req_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_next    = r_state;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_rdata = '0;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            stall  = 1'b1;
            w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? WRITEBACK : REFILL;
          end else if (w_hit && !cpu_wr) begin
            cpu_rdata = r_data[w_idx][w_off];
          end
        end
        WRITEBACK: begin
          stall     = 1'b1;
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {r_tag[r_req_idx], r_req_idx, {(OFF_W + 2){1'b0}}};
          mem_wdata = r_data[r_req_idx];
          if (mem_ready) w_next = REFILL;
        end
        REFILL: begin
          stall    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = {r_req_tag, r_req_idx, {(OFF_W + 2){1'b0}}};
          if (mem_ready) w_next = DONE;
        end
        DONE: begin
          if (!r_req_wr) cpu_rdata = r_data[r_req_idx][r_req_off];
          w_next = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= '0;
      r_dirty    <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit && cpu_wr) r_dirty[w_idx] <= 1'b1;
      if (w_install) begin
        r_valid[r_req_idx] <= 1'b1;
        r_dirty[r_req_idx] <= r_req_wr;
      end
      if (w_hit && (r_hit_cnt != '1))   r_hit_cnt  <= r_hit_cnt + CNT_W'(1);
      if (w_miss && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

  // NOTE: tag/data arrays and the request latch are deliberately not reset;
  // valid bits and the FSM gate every use, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_miss) begin
      r_req_tag   <= w_tag;
      r_req_idx   <= w_idx;
      r_req_off   <= w_off;
      r_req_wr    <= cpu_wr;
      r_req_wdata <= cpu_wdata;
    end
    if (w_hit && cpu_wr) r_data[w_idx][w_off] <= cpu_wdata;
    if (w_install) begin
      r_data[r_req_idx] <= w_fill;
      r_tag[r_req_idx]  <= r_req_tag;
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: cold miss, hits, dirty write-back, write
// miss merge, reset abort, and counter saturation on a CNT_W=4 instance.
module tb_dcache_wb;

  localparam int LW = 128;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          cpu_rd, cpu_wr;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          stall, hit, mem_req, mem_we, mem_ready;
  logic [31:0]   mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;
  logic [15:0]   hit_cnt, miss_cnt;

  logic          s_cpu_rd, s_cpu_wr;
  logic [31:0]   s_cpu_addr, s_cpu_wdata, s_cpu_rdata;
  logic          s_stall, s_hit, s_mem_req, s_mem_we, s_mem_ready;
  logic [31:0]   s_mem_addr;
  logic [LW-1:0] s_mem_wdata, s_mem_rdata;
  logic [3:0]    s_hit_cnt, s_miss_cnt;

  dcache_wb u_dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .stall(stall), .hit(hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  dcache_wb #(.CNT_W(4)) u_dut_sat (
    .clk(clk), .reset(reset),
    .cpu_rd(s_cpu_rd), .cpu_wr(s_cpu_wr), .cpu_addr(s_cpu_addr), .cpu_wdata(s_cpu_wdata),
    .cpu_rdata(s_cpu_rdata), .stall(s_stall), .hit(s_hit),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(s_mem_rdata), .mem_ready(s_mem_ready),
    .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Results of the last miss sequence.
  int            m_stalls, m_tx;
  logic [31:0]   m_addr [2];
  logic          m_we   [2];
  logic [LW-1:0] m_data [2];
  logic [31:0]   m_rdata;
  logic          m_hit, m_stable, m_timeout;

  // Results of the last single-cycle access.
  logic          a_hit, a_stall;
  logic [31:0]   a_rdata;

  // Refill lines, word3..word0.
  localparam logic [LW-1:0] LINE1 = {32'h33333333, 32'h22222222, 32'hCAFEF00D, 32'h11111111};
  localparam logic [LW-1:0] LINE2 = {32'h44444444, 32'hDEADBEEF, 32'h55555555, 32'h66666666};
  localparam logic [LW-1:0] LINE3 = {32'h77777777, 32'h88888888, 32'h99999999, 32'hAAAAAAAA};
  localparam logic [LW-1:0] LINEX = {32'hBAD0BAD3, 32'hBAD0BAD2, 32'hBAD0BAD1, 32'hBAD0BAD0};
  localparam logic [LW-1:0] LINEY = {32'h0C0C0C03, 32'h0C0C0C02, 32'h0C0C0C01, 32'h0C0C0C00};

  // One-cycle IDLE access; entered and left at posedge+1.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    a_hit = hit; a_stall = stall; a_rdata = cpu_rdata;
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  // Issue a request and act as memory until DONE; w0/w1 are the cycles
  // mem_req stays high before mem_ready for the first/second transaction.
  task automatic do_miss(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int w0, input int w1,
                         input logic [LW-1:0] rline);
    int  rq;
    int  wt;
    bit  done;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata; mem_rdata = rline;
    m_stalls = 0; m_tx = 0; m_stable = 1'b1; m_timeout = 1'b1; m_rdata = '0; m_hit = 1'b0;
    rq = 0; done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (stall) m_stalls++;
      if (mem_req) begin
        if (m_tx < 2) begin
          if (rq == 0) begin
            m_addr[m_tx] = mem_addr; m_we[m_tx] = mem_we; m_data[m_tx] = mem_wdata;
          end else if (mem_addr !== m_addr[m_tx] || mem_we !== m_we[m_tx] ||
                       mem_wdata !== m_data[m_tx]) begin
            m_stable = 1'b0;
          end
          rq++;
          wt = (m_tx == 0) ? w0 : w1;
          if (rq == wt + 1) begin mem_ready = 1'b1; rq = 0; m_tx++; end
        end else begin
          mem_ready = 1'b1; m_tx++;
        end
      end else if (!stall && m_stalls > 0) begin
        m_rdata = cpu_rdata; m_hit = hit; done = 1'b1; m_timeout = 1'b0;
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
    end
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_rd = 1'b1; cpu_addr = 32'h104;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", hit); end
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_req_we got=%b%b exp=00", mem_req, mem_we); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== '0) begin failures++; $display("FAIL reset_mem_bus got=%h/%h exp=0", mem_addr, mem_wdata); end
    checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", cpu_rdata); end
    checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
    cpu_rd = 1'b0; cpu_addr = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_cold_read();
    do_miss(1'b1, 1'b0, 32'h104, 32'h0, 3, 0, LINE1);
    checks++; if (m_timeout !== 1'b0) begin failures++; $display("FAIL cold_timeout got=1 exp=0"); end
    checks++; if (m_stalls != 5) begin failures++; $display("FAIL cold_stall_len got=%0d exp=5", m_stalls); end
    checks++; if (m_tx != 1 || m_addr[0] !== 32'h100 || m_we[0] !== 1'b0) begin failures++; $display("FAIL cold_refill tx=%0d addr=%h we=%b exp=1/00000100/0", m_tx, m_addr[0], m_we[0]); end
    checks++; if (m_stable !== 1'b1) begin failures++; $display("FAIL cold_bus_stable got=0 exp=1"); end
    checks++; if (m_rdata !== 32'hCAFEF00D || m_hit !== 1'b0) begin failures++; $display("FAIL cold_done rdata=%h hit=%b exp=cafef00d/0", m_rdata, m_hit); end
    checks++; if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin failures++; $display("FAIL cold_counters got=%0d/%0d exp=0/1", hit_cnt, miss_cnt); end
  endtask

  task automatic test_read_hit();
    access(1'b1, 1'b0, 32'h104, 32'h0);
    checks++; if (a_hit !== 1'b1 || a_stall !== 1'b0 || a_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL hit_104 hit=%b stall=%b rdata=%h exp=1/0/cafef00d", a_hit, a_stall, a_rdata); end
    checks++; if (hit_cnt !== 16'd1) begin failures++; $display("FAIL hit_cnt_1 got=%0d exp=1", hit_cnt); end
    access(1'b1, 1'b0, 32'h10C, 32'h0);
    checks++; if (a_hit !== 1'b1 || a_rdata !== 32'h33333333) begin failures++; $display("FAIL hit_10c hit=%b rdata=%h exp=1/33333333", a_hit, a_rdata); end
    access(1'b0, 1'b0, 32'h104, 32'h0);
    checks++; if (a_hit !== 1'b0 || a_stall !== 1'b0 || a_rdata !== 32'h0) begin failures++; $display("FAIL no_request hit=%b stall=%b rdata=%h exp=0/0/0", a_hit, a_stall, a_rdata); end
    checks++; if (hit_cnt !== 16'd2) begin failures++; $display("FAIL hit_cnt_2 got=%0d exp=2", hit_cnt); end
  endtask

  task automatic test_write_back();
    // rd and wr together act as a store.
    access(1'b1, 1'b1, 32'h108, 32'h12345678);
    checks++; if (a_hit !== 1'b1 || a_stall !== 1'b0) begin failures++; $display("FAIL wr_hit hit=%b stall=%b exp=1/0", a_hit, a_stall); end
    access(1'b1, 1'b0, 32'h108, 32'h0);
    checks++; if (a_hit !== 1'b1 || a_rdata !== 32'h12345678) begin failures++; $display("FAIL wr_readback hit=%b rdata=%h exp=1/12345678", a_hit, a_rdata); end
    checks++; if (hit_cnt !== 16'd4) begin failures++; $display("FAIL hit_cnt_4 got=%0d exp=4", hit_cnt); end
    do_miss(1'b1, 1'b0, 32'h1108, 32'h0, 1, 0, LINE2);
    checks++; if (m_timeout !== 1'b0 || m_tx != 2) begin failures++; $display("FAIL wb_tx timeout=%b tx=%0d exp=0/2", m_timeout, m_tx); end
    checks++; if (m_addr[0] !== 32'h100 || m_we[0] !== 1'b1) begin failures++; $display("FAIL wb_addr addr=%h we=%b exp=00000100/1", m_addr[0], m_we[0]); end
    checks++; if (m_data[0] !== {32'h33333333, 32'h12345678, 32'hCAFEF00D, 32'h11111111}) begin failures++; $display("FAIL wb_data got=%h", m_data[0]); end
    checks++; if (m_addr[1] !== 32'h1100 || m_we[1] !== 1'b0) begin failures++; $display("FAIL wb_refill addr=%h we=%b exp=00001100/0", m_addr[1], m_we[1]); end
    checks++; if (m_stalls != 4 || m_stable !== 1'b1) begin failures++; $display("FAIL wb_stall_len got=%0d stable=%b exp=4/1", m_stalls, m_stable); end
    checks++; if (m_rdata !== 32'hDEADBEEF || miss_cnt !== 16'd2) begin failures++; $display("FAIL wb_done rdata=%h miss=%0d exp=deadbeef/2", m_rdata, miss_cnt); end
  endtask

  task automatic test_write_miss();
    do_miss(1'b0, 1'b1, 32'h20C, 32'hA5A5A5A5, 2, 0, LINE3);
    checks++; if (m_timeout !== 1'b0 || m_tx != 1 || m_addr[0] !== 32'h200 || m_we[0] !== 1'b0) begin failures++; $display("FAIL wm_refill tx=%0d addr=%h we=%b exp=1/00000200/0", m_tx, m_addr[0], m_we[0]); end
    checks++; if (m_stalls != 4 || m_hit !== 1'b0) begin failures++; $display("FAIL wm_stall_len got=%0d hit=%b exp=4/0", m_stalls, m_hit); end
    access(1'b1, 1'b0, 32'h20C, 32'h0);
    checks++; if (a_hit !== 1'b1 || a_rdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL wm_merged hit=%b rdata=%h exp=1/a5a5a5a5", a_hit, a_rdata); end
    access(1'b1, 1'b0, 32'h208, 32'h0);
    checks++; if (a_hit !== 1'b1 || a_rdata !== 32'h88888888) begin failures++; $display("FAIL wm_neighbour hit=%b rdata=%h exp=1/88888888", a_hit, a_rdata); end
    checks++; if (hit_cnt !== 16'd6 || miss_cnt !== 16'd3) begin failures++; $display("FAIL wm_counters got=%0d/%0d exp=6/3", hit_cnt, miss_cnt); end
    do_miss(1'b1, 1'b0, 32'h10C, 32'h0, 0, 1, LINE1);
    checks++; if (m_timeout !== 1'b0 || m_tx != 2 || m_addr[0] !== 32'h200 || m_we[0] !== 1'b1) begin failures++; $display("FAIL wm_evict tx=%0d addr=%h we=%b exp=2/00000200/1", m_tx, m_addr[0], m_we[0]); end
    checks++; if (m_data[0] !== {32'hA5A5A5A5, 32'h88888888, 32'h99999999, 32'hAAAAAAAA}) begin failures++; $display("FAIL wm_evict_data got=%h", m_data[0]); end
    checks++; if (m_stalls != 4 || m_rdata !== 32'h33333333 || miss_cnt !== 16'd4) begin failures++; $display("FAIL wm_reload stalls=%0d rdata=%h miss=%0d exp=4/33333333/4", m_stalls, m_rdata, miss_cnt); end
  endtask

  task automatic test_reset_abort();
    bit seen;
    seen = 1'b0;
    cpu_rd = 1'b1; cpu_addr = 32'h304; mem_rdata = LINEX;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (mem_req && !mem_we) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL abort_refill_start got=0 exp=1"); end
    mem_ready = 1'b1; reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL abort_outputs req=%b stall=%b exp=0/0", mem_req, stall); end
    @(posedge clk); #1;
    mem_ready = 1'b0; cpu_rd = 1'b0; cpu_addr = '0;
    reset = 1'b0;
    checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin failures++; $display("FAIL abort_counters got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
    do_miss(1'b1, 1'b0, 32'h304, 32'h0, 1, 0, LINEY);
    checks++; if (m_timeout !== 1'b0 || m_tx != 1 || m_addr[0] !== 32'h300 || m_stalls != 3) begin failures++; $display("FAIL abort_remiss tx=%0d addr=%h stalls=%0d exp=1/00000300/3", m_tx, m_addr[0], m_stalls); end
    checks++; if (m_rdata !== 32'h0C0C0C01 || miss_cnt !== 16'd1) begin failures++; $display("FAIL abort_reload rdata=%h miss=%0d exp=0c0c0c01/1", m_rdata, miss_cnt); end
  endtask

  task automatic test_saturation();
    // mem_ready held high: one miss completes at once, then every cycle hits.
    s_mem_rdata = {96'h0, 32'h0BADF00D};
    s_mem_ready = 1'b1; s_cpu_rd = 1'b1; s_cpu_addr = 32'h0;
    repeat (25) @(posedge clk);
    @(negedge clk);
    checks++; if (s_hit_cnt !== 4'd15) begin failures++; $display("FAIL sat_hit_cnt got=%0d exp=15", s_hit_cnt); end
    checks++; if (s_miss_cnt !== 4'd1) begin failures++; $display("FAIL sat_miss_cnt got=%0d exp=1", s_miss_cnt); end
    checks++; if (s_hit !== 1'b1 || s_cpu_rdata !== 32'h0BADF00D) begin failures++; $display("FAIL sat_hit hit=%b rdata=%h exp=1/0badf00d", s_hit, s_cpu_rdata); end
    @(posedge clk); #1;
    s_cpu_rd = 1'b0; s_mem_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    s_cpu_rd = 1'b0; s_cpu_wr = 1'b0; s_cpu_addr = '0; s_cpu_wdata = '0;
    s_mem_rdata = '0; s_mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_cold_read();
    test_read_hit();
    test_write_back();
    test_write_miss();
    test_reset_abort();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
